// File: rtl/filter_pkg.sv
// Shared types and defaults for the filter frame scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package filter_pkg;

    typedef enum logic [1:0] {
        FILTER_NONE    = 2'd0,
        FILTER_BLUR    = 2'd1,
        FILTER_EDGE    = 2'd2,
        FILTER_SHARPEN = 2'd3
    } filter_t;

    typedef logic [1:0] freq_level_t;

    typedef enum logic {
        WAIT_SOP = 1'b0,
        IN_FRAME = 1'b1
    } sched_state_t;

    localparam int DEF_STABLE_FRAMES = 3;
    localparam int DEF_MAX_BEATS     = 76800;   // 320x240 pixels

    localparam filter_t     FILTER_RESET = FILTER_NONE;
    localparam freq_level_t FREQ_RESET   = 2'd0;

endpackage

// File: rtl/flag_debouncer.sv
// Debounces a 2-bit level sampled once per strobe: level follows flag only after STABLE_FRAMES equal samples.
// Latency: level updates the cycle after the qualifying strobe; changed is combinational in the strobe cycle.
// Backpressure: none; state only advances on strobe.
//
// Ports: clk, reset (async, active-high), strobe (sample enable), flag (input level),
//        level (debounced output), changed (high when this strobe will alter level).
module flag_debouncer
    import filter_pkg::*;
#(
    parameter int STABLE_FRAMES = DEF_STABLE_FRAMES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       strobe,
    input  logic [1:0] flag,
    output logic [1:0] level,
    output logic       changed
);

    localparam logic [3:0] STABLE_LIMIT = 4'(STABLE_FRAMES);

    logic [3:0]  stab_cnt;
    logic [3:0]  cnt_nxt;
    freq_level_t prev_flag;

    // Run length of equal samples, restarting at 1 on any change and
    // saturating at the acceptance threshold.
    always_comb begin
        cnt_nxt = stab_cnt;
        if (flag != prev_flag) begin
            cnt_nxt = 4'd1;
        end else if (stab_cnt < STABLE_LIMIT) begin
            cnt_nxt = stab_cnt + 4'd1;
        end
    end

    assign changed = strobe && (cnt_nxt == STABLE_LIMIT) && (flag != level);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stab_cnt  <= 4'd0;
            prev_flag <= FREQ_RESET;
            level     <= FREQ_RESET;
        end else if (strobe) begin
            stab_cnt  <= cnt_nxt;
            prev_flag <= flag;
            if (cnt_nxt == STABLE_LIMIT) begin
                level <= flag;
            end
        end
    end

endmodule

// File: rtl/filter_frame_scheduler.sv
// Tracks SOP/EOP on an observed pixel stream and applies filter/pitch changes only at frame boundaries.
// Latency: filter_num, freq_level, update_pulse and sync_err change 1 cycle after the triggering beat.
// Backpressure: passive observer; only valid_in&&ready_in beats advance state, all other cycles hold.
//
// Ports: clk, reset (async, active-high); filter_req, freq_flag (requested settings);
//        sop_in, eop_in, valid_in, ready_in (observed handshake);
//        filter_num, freq_level (applied settings), frame_active, update_pulse, sync_err.
// Optional: define FILTER_SCHED_WATCHDOG_EN to abort frames that run MAX_BEATS beats without EOP.
module filter_frame_scheduler
    import filter_pkg::*;
#(
    parameter int STABLE_FRAMES = DEF_STABLE_FRAMES,
    parameter int MAX_BEATS     = DEF_MAX_BEATS
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] filter_req,
    input  logic [1:0] freq_flag,
    input  logic       sop_in,
    input  logic       eop_in,
    input  logic       valid_in,
    input  logic       ready_in,
    output logic [1:0] filter_num,
    output logic [1:0] freq_level,
    output logic       frame_active,
    output logic       update_pulse,
    output logic       sync_err
);

    if (STABLE_FRAMES < 1 || STABLE_FRAMES > 15) begin : g_bad_stable
        $error("STABLE_FRAMES must be in 1..15");
    end
    if (MAX_BEATS < 2) begin : g_bad_max
        $error("MAX_BEATS must be at least 2");
    end

    sched_state_t state_q;
    sched_state_t state_nxt;
    filter_t      filter_q;
    logic         beat;
    logic         boundary;
    logic         frame_err;
    logic         level_changed;
    logic         filter_changed;

`ifdef FILTER_SCHED_WATCHDOG_EN
    localparam int               CNT_W      = $clog2(MAX_BEATS + 1);
    localparam logic [CNT_W-1:0] BEAT_LIMIT = CNT_W'(MAX_BEATS);

    // Beats seen in the current frame, including its SOP beat.
    logic [CNT_W-1:0] beat_cnt_q;
    logic [CNT_W-1:0] beat_cnt_nxt;
`endif

    assign beat = valid_in && ready_in;

    always_comb begin
        state_nxt = state_q;
        boundary  = 1'b0;
        frame_err = 1'b0;
`ifdef FILTER_SCHED_WATCHDOG_EN
        beat_cnt_nxt = beat_cnt_q;
`endif
        if (beat) begin
            if (state_q == WAIT_SOP) begin
                if (sop_in && eop_in) begin
                    // Single-beat frame: complete on the spot.
                    boundary = 1'b1;
                end else if (sop_in) begin
                    state_nxt = IN_FRAME;
`ifdef FILTER_SCHED_WATCHDOG_EN
                    beat_cnt_nxt = CNT_W'(1);
`endif
                end else if (eop_in) begin
                    frame_err = 1'b1;   // stray EOP outside a frame
                end
            end else begin
                if (sop_in) begin
                    // A new SOP inside a frame restarts it; the truncated
                    // frame never reaches a boundary, even if eop_in is set.
                    frame_err = 1'b1;
`ifdef FILTER_SCHED_WATCHDOG_EN
                    beat_cnt_nxt = CNT_W'(1);
`endif
                end else if (eop_in) begin
                    boundary  = 1'b1;
                    state_nxt = WAIT_SOP;
                end else begin
`ifdef FILTER_SCHED_WATCHDOG_EN
                    if (beat_cnt_q + 1'b1 == BEAT_LIMIT) begin
                        frame_err = 1'b1;
                        state_nxt = WAIT_SOP;
                    end else begin
                        beat_cnt_nxt = beat_cnt_q + 1'b1;
                    end
`endif
                end
            end
        end
    end

    assign filter_changed = (filter_t'(filter_req) != filter_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= WAIT_SOP;
            filter_q     <= FILTER_RESET;
            update_pulse <= 1'b0;
            sync_err     <= 1'b0;
        end else begin
            state_q      <= state_nxt;
            sync_err     <= frame_err;
            update_pulse <= boundary && (filter_changed || level_changed);
            if (boundary) begin
                filter_q <= filter_t'(filter_req);
            end
        end
    end

`ifdef FILTER_SCHED_WATCHDOG_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beat_cnt_q <= '0;
        end else begin
            beat_cnt_q <= beat_cnt_nxt;
        end
    end
`endif

    flag_debouncer #(
        .STABLE_FRAMES (STABLE_FRAMES)
    ) u_flag_debouncer (
        .clk     (clk),
        .reset   (reset),
        .strobe  (boundary),
        .flag    (freq_flag),
        .level   (freq_level),
        .changed (level_changed)
    );

    assign filter_num   = filter_q;
    assign frame_active = (state_q == IN_FRAME);

endmodule

// File: tb/tb_filter_frame_scheduler.sv
module tb_filter_frame_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] filter_req;
    logic [1:0] freq_flag;
    logic       sop_in, eop_in, valid_in, ready_in;
    logic [1:0] filter_num, freq_level;
    logic       frame_active, update_pulse, sync_err;

    int checks   = 0;
    int fails    = 0;
    int serr_cnt = 0;
    int upd_cnt  = 0;

    always #5 clk = ~clk;

    filter_frame_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .filter_req   (filter_req),
        .freq_flag    (freq_flag),
        .sop_in       (sop_in),
        .eop_in       (eop_in),
        .valid_in     (valid_in),
        .ready_in     (ready_in),
        .filter_num   (filter_num),
        .freq_level   (freq_level),
        .frame_active (frame_active),
        .update_pulse (update_pulse),
        .sync_err     (sync_err)
    );

`ifdef FILTER_SCHED_WATCHDOG_EN
    logic [1:0] wd_filter_num, wd_freq_level;
    logic       wd_frame_active, wd_update_pulse, wd_sync_err;

    filter_frame_scheduler #(.MAX_BEATS(16)) dut_wd (
        .clk          (clk),
        .reset        (reset),
        .filter_req   (filter_req),
        .freq_flag    (freq_flag),
        .sop_in       (sop_in),
        .eop_in       (eop_in),
        .valid_in     (valid_in),
        .ready_in     (ready_in),
        .filter_num   (wd_filter_num),
        .freq_level   (wd_freq_level),
        .frame_active (wd_frame_active),
        .update_pulse (wd_update_pulse),
        .sync_err     (wd_sync_err)
    );
`endif

    // Pulse counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (sync_err === 1'b1) serr_cnt++;
        if (update_pulse === 1'b1) upd_cnt++;
    end

    // One cycle of stimulus; returns 1 time unit after the sampling edge.
    task automatic drive(input logic v, input logic r, input logic s, input logic e);
        @(negedge clk);
        valid_in = v; ready_in = r; sop_in = s; eop_in = e;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; valid_in = 1'b0; ready_in = 1'b0; sop_in = 1'b0; eop_in = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (filter_num !== 2'd0) begin fails++; $display("FAIL reset_filter_num: got %0d want 0", filter_num); end
        checks++; if (freq_level !== 2'd0) begin fails++; $display("FAIL reset_freq_level: got %0d want 0", freq_level); end
        checks++; if (frame_active !== 1'b0) begin fails++; $display("FAIL reset_frame_active: got %b want 0", frame_active); end
        checks++; if (update_pulse !== 1'b0) begin fails++; $display("FAIL reset_update_pulse: got %b want 0", update_pulse); end
        checks++; if (sync_err !== 1'b0) begin fails++; $display("FAIL reset_sync_err: got %b want 0", sync_err); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_nonbeat();
        do_reset();
        filter_req = 2'd2; freq_flag = 2'd0;
        drive(1'b1, 1'b0, 1'b1, 1'b0);   // valid without ready
        checks++; if (frame_active !== 1'b0) begin fails++; $display("FAIL nonbeat_sop: frame_active got %b want 0", frame_active); end
        drive(1'b0, 1'b1, 1'b1, 1'b1);   // ready without valid
        checks++; if (filter_num !== 2'd0) begin fails++; $display("FAIL nonbeat_filter: got %0d want 0", filter_num); end
        checks++; if (update_pulse !== 1'b0) begin fails++; $display("FAIL nonbeat_update: got %b want 0", update_pulse); end
        filter_req = 2'd0;
    endtask

    task automatic test_filter_change();
        do_reset();
        filter_req = 2'd0; freq_flag = 2'd0;
        drive(1'b1, 1'b1, 1'b1, 1'b0);   // beat 1: SOP
        checks++; if (frame_active !== 1'b1) begin fails++; $display("FAIL fc_active: got %b want 1", frame_active); end
        for (int i = 2; i <= 49; i++) drive(1'b1, 1'b1, 1'b0, 1'b0);
        filter_req = 2'd2;
        for (int i = 50; i <= 99; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0);
            checks++; if (filter_num !== 2'd0) begin fails++; $display("FAIL fc_midframe beat %0d: filter_num got %0d want 0", i, filter_num); end
        end
        drive(1'b1, 1'b1, 1'b0, 1'b1);   // beat 100: EOP
        checks++; if (filter_num !== 2'd2) begin fails++; $display("FAIL fc_eop_filter: got %0d want 2", filter_num); end
        checks++; if (update_pulse !== 1'b1) begin fails++; $display("FAIL fc_eop_pulse: got %b want 1", update_pulse); end
        checks++; if (frame_active !== 1'b0) begin fails++; $display("FAIL fc_eop_active: got %b want 0", frame_active); end
        idle();
        checks++; if (update_pulse !== 1'b0) begin fails++; $display("FAIL fc_pulse_width: got %b want 0", update_pulse); end
        checks++; if (filter_num !== 2'd2) begin fails++; $display("FAIL fc_hold: got %0d want 2", filter_num); end
    endtask

    task automatic test_eop_in_wait();
        serr_cnt = 0;
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        checks++; if (sync_err !== 1'b1) begin fails++; $display("FAIL stray_eop_err: got %b want 1", sync_err); end
        checks++; if (frame_active !== 1'b0) begin fails++; $display("FAIL stray_eop_active: got %b want 0", frame_active); end
        checks++; if (update_pulse !== 1'b0) begin fails++; $display("FAIL stray_eop_update: got %b want 0", update_pulse); end
        idle();
        idle();
        checks++; if (serr_cnt !== 1) begin fails++; $display("FAIL stray_eop_count: got %0d want 1", serr_cnt); end
    endtask

    task automatic test_freq_stable();
        do_reset();
        filter_req = 2'd0; freq_flag = 2'd3;
        for (int f = 1; f <= 3; f++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b0);
            for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, 1'b0);
            drive(1'b1, 1'b1, 1'b0, 1'b1);
            checks++; if (freq_level !== ((f == 3) ? 2'd3 : 2'd0)) begin fails++; $display("FAIL fs_level frame %0d: got %0d want %0d", f, freq_level, (f == 3) ? 3 : 0); end
            checks++; if (update_pulse !== (f == 3)) begin fails++; $display("FAIL fs_pulse frame %0d: got %b want %b", f, update_pulse, f == 3); end
        end
        idle();
        checks++; if (freq_level !== 2'd3) begin fails++; $display("FAIL fs_hold: got %0d want 3", freq_level); end
    endtask

    task automatic test_freq_alternating();
        logic [1:0] flags [4];
        flags[0] = 2'd1; flags[1] = 2'd2; flags[2] = 2'd1; flags[3] = 2'd2;
        do_reset();
        filter_req = 2'd0;
        upd_cnt = 0;
        for (int f = 0; f < 4; f++) begin
            freq_flag = flags[f];
            drive(1'b1, 1'b1, 1'b1, 1'b0);
            drive(1'b1, 1'b1, 1'b0, 1'b1);
            checks++; if (freq_level !== 2'd0) begin fails++; $display("FAIL alt_level frame %0d: got %0d want 0", f, freq_level); end
        end
        idle();
        idle();
        checks++; if (upd_cnt !== 0) begin fails++; $display("FAIL alt_pulses: got %0d want 0", upd_cnt); end
    endtask

    task automatic test_resync();
        do_reset();
        filter_req = 2'd1; freq_flag = 2'd0;
        serr_cnt = 0;
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 2; i <= 49; i++) drive(1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b0);   // beat 50: second SOP
        checks++; if (sync_err !== 1'b1) begin fails++; $display("FAIL rs_err: got %b want 1", sync_err); end
        checks++; if (frame_active !== 1'b1) begin fails++; $display("FAIL rs_active: got %b want 1", frame_active); end
        checks++; if (update_pulse !== 1'b0) begin fails++; $display("FAIL rs_no_update: got %b want 0", update_pulse); end
        for (int i = 51; i <= 99; i++) drive(1'b1, 1'b1, 1'b0, 1'b0);
        checks++; if (frame_active !== 1'b1 || filter_num !== 2'd0) begin fails++; $display("FAIL rs_mid: active %b filter %0d want 1/0", frame_active, filter_num); end
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        checks++; if (filter_num !== 2'd1) begin fails++; $display("FAIL rs_eop_filter: got %0d want 1", filter_num); end
        checks++; if (update_pulse !== 1'b1) begin fails++; $display("FAIL rs_eop_pulse: got %b want 1", update_pulse); end
        idle();
        checks++; if (serr_cnt !== 1) begin fails++; $display("FAIL rs_err_count: got %0d want 1", serr_cnt); end
    endtask

    task automatic test_long_frame();
        do_reset();
        filter_req = 2'd2; freq_flag = 2'd0;
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 2; i <= 15; i++) drive(1'b1, 1'b1, 1'b0, 1'b0);
`ifdef FILTER_SCHED_WATCHDOG_EN
        checks++; if (wd_frame_active !== 1'b1) begin fails++; $display("FAIL wd_before: active got %b want 1", wd_frame_active); end
`endif
        drive(1'b1, 1'b1, 1'b0, 1'b0);   // beat 16, still no EOP
        // Default-limit instance must not time out.
        checks++; if (frame_active !== 1'b1) begin fails++; $display("FAIL long_active: got %b want 1", frame_active); end
        checks++; if (sync_err !== 1'b0) begin fails++; $display("FAIL long_err: got %b want 0", sync_err); end
`ifdef FILTER_SCHED_WATCHDOG_EN
        checks++; if (wd_sync_err !== 1'b1) begin fails++; $display("FAIL wd_err: got %b want 1", wd_sync_err); end
        checks++; if (wd_frame_active !== 1'b0) begin fails++; $display("FAIL wd_active: got %b want 0", wd_frame_active); end
        checks++; if (wd_filter_num !== 2'd0) begin fails++; $display("FAIL wd_filter: got %0d want 0", wd_filter_num); end
        checks++; if (wd_update_pulse !== 1'b0) begin fails++; $display("FAIL wd_update: got %b want 0", wd_update_pulse); end
`endif
    endtask

    task automatic test_reset_midframe();
        do_reset();
        filter_req = 2'd3; freq_flag = 2'd0;
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 2; i <= 10; i++) drive(1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1; valid_in = 1'b0; sop_in = 1'b0; eop_in = 1'b0;
        #1;
        checks++; if ({filter_num, freq_level, frame_active, update_pulse, sync_err} !== 7'd0) begin
            fails++; $display("FAIL rm_reset_outputs: got %b want 0000000", {filter_num, freq_level, frame_active, update_pulse, sync_err}); end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        upd_cnt = 0;
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        checks++; if (filter_num !== 2'd3) begin fails++; $display("FAIL rm_filter: got %0d want 3", filter_num); end
        checks++; if (update_pulse !== 1'b1) begin fails++; $display("FAIL rm_pulse: got %b want 1", update_pulse); end
        checks++; if (frame_active !== 1'b0) begin fails++; $display("FAIL rm_active: got %b want 0", frame_active); end
        checks++; if (sync_err !== 1'b0) begin fails++; $display("FAIL rm_err: got %b want 0", sync_err); end
        idle();
        idle();
        checks++; if (upd_cnt !== 1) begin fails++; $display("FAIL rm_pulse_count: got %0d want 1", upd_cnt); end
    endtask

    initial begin
        reset = 1'b1; filter_req = 2'd0; freq_flag = 2'd0;
        sop_in = 1'b0; eop_in = 1'b0; valid_in = 1'b0; ready_in = 1'b0;
        test_reset();
        test_nonbeat();
        test_filter_change();
        test_eop_in_wait();
        test_freq_stable();
        test_freq_alternating();
        test_resync();
        test_long_frame();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
